// File: rtl/fa_pkg.sv
// rtl/fa_pkg.sv - shared bit positions, widths and defaults for the full-adder stream wrapper.
package fa_pkg;

  localparam int A_BIT    = 0;
  localparam int B_BIT    = 1;
  localparam int CIN_BIT  = 2;
  localparam int S_BIT    = 3;
  localparam int COUT_BIT = 4;

  localparam int IN_W  = 3;
  localparam int OUT_W = 5;

  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/fa_stream_wrapper_if.sv
// rtl/fa_stream_wrapper_if.sv - operand-in / result-out handshake bundle.
interface fa_stream_wrapper_if;
  import fa_pkg::*;

  logic             valid_in;
  logic             ready_in;
  logic [IN_W-1:0]  data_bus_in;
  logic             valid_out;
  logic             ready_out;
  logic [OUT_W-1:0] data_bus_out;

  // master drives operands and accepts results; slave is the wrapper itself
  modport master (
    output valid_in, data_bus_in, ready_out,
    input  ready_in, valid_out, data_bus_out
  );

  modport slave (
    input  valid_in, data_bus_in, ready_out,
    output ready_in, valid_out, data_bus_out
  );

endinterface

// File: rtl/fa_result_fifo.sv
// rtl/fa_result_fifo.sv - result buffer, power-of-two depth, reads zero when empty.
module fa_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // guarding here keeps the buffer safe even if a caller ignores full/empty
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fa_stream_wrapper.sv
// rtl/fa_stream_wrapper.sv - registered full adder with buffered, in-order results and an accept counter.
module fa_stream_wrapper
  import fa_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  fa_stream_wrapper_if.slave     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       txn_count
);

  logic [OUT_W-1:0] result;
  logic [CNT_W-1:0] txn_count_q, txn_count_d;
  logic             accept;
  logic             fifo_full;
  logic             fifo_empty;
  logic             a, b, cin;

  assign a   = bus.data_bus_in[A_BIT];
  assign b   = bus.data_bus_in[B_BIT];
  assign cin = bus.data_bus_in[CIN_BIT];

  always_comb begin
    result           = '0;
    result[A_BIT]    = a;
    result[B_BIT]    = b;
    result[CIN_BIT]  = cin;
    result[S_BIT]    = a ^ b ^ cin;
    result[COUT_BIT] = (a & b) | (a & cin) | (b & cin);
  end

  // ready_in comes straight from the buffer level, never from ready_out
  assign bus.ready_in  = !fifo_full;
  assign bus.valid_out = !fifo_empty;
  assign accept        = bus.valid_in && !fifo_full;

  always_comb begin
    txn_count_d = txn_count_q;
    if (accept) begin
      txn_count_d = txn_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_q <= '0;
    end else begin
      txn_count_q <= txn_count_d;
    end
  end

  assign txn_count = txn_count_q;

  fa_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (result),
    .pop       (bus.ready_out),
    .pop_data  (bus.data_bus_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

endmodule

// File: tb/tb_fa_stream_wrapper.sv
// tb/tb_fa_stream_wrapper.sv - directed self-checking bench for fa_stream_wrapper.
module tb_fa_stream_wrapper;

  logic        clk;
  logic        rst;
  logic [2:0]  level;
  logic [15:0] txn_count;
  logic [1:0]  level2;
  logic [1:0]  txn_count2;

  int checks;
  int failures;

  logic [4:0] exp_tab [8];
  logic [2:0] vals [5];

  fa_stream_wrapper_if u_if ();
  fa_stream_wrapper_if u_if2 ();

  fa_stream_wrapper #(.DEPTH(4), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (u_if),
    .level     (level),
    .txn_count (txn_count)
  );

  fa_stream_wrapper #(.DEPTH(2), .CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (u_if2),
    .level     (level2),
    .txn_count (txn_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    // {cout, s, cin, b, a} for operand index {cin, b, a}
    exp_tab[0] = 5'b00000; exp_tab[1] = 5'b01001;
    exp_tab[2] = 5'b01010; exp_tab[3] = 5'b10011;
    exp_tab[4] = 5'b01100; exp_tab[5] = 5'b10101;
    exp_tab[6] = 5'b10110; exp_tab[7] = 5'b11111;
    vals[0] = 3'd1; vals[1] = 3'd2; vals[2] = 3'd4; vals[3] = 3'd5; vals[4] = 3'd6;

    rst = 1'b1;
    u_if.valid_in = 1'b0;  u_if.data_bus_in = '0;  u_if.ready_out = 1'b0;
    u_if2.valid_in = 1'b0; u_if2.data_bus_in = '0; u_if2.ready_out = 1'b0;
    step();
    check("rst_valid_out", 32'(u_if.valid_out), 32'd0);
    check("rst_data_out", 32'(u_if.data_bus_out), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_txn", 32'(txn_count), 32'd0);
    check("rst_ready_in", 32'(u_if.ready_in), 32'd1);
    rst = 1'b0;
    step();
    check("post_rst_ready_in", 32'(u_if.ready_in), 32'd1);

    // single operand a=1 b=1 cin=0
    u_if.valid_in = 1'b1; u_if.data_bus_in = 3'b011; u_if.ready_out = 1'b1;
    step();
    u_if.valid_in = 1'b0;
    check("one_valid_out", 32'(u_if.valid_out), 32'd1);
    check("one_data_out", 32'(u_if.data_bus_out), 32'h13);
    check("one_txn", 32'(txn_count), 32'd1);
    step();
    check("one_drained_valid", 32'(u_if.valid_out), 32'd0);
    check("one_drained_data", 32'(u_if.data_bus_out), 32'd0);

    // all eight operands back-to-back with downstream always ready
    for (int i = 0; i < 8; i++) begin
      u_if.valid_in = 1'b1; u_if.data_bus_in = 3'(i);
      step();
      check($sformatf("tt_data_%0d", i), 32'(u_if.data_bus_out), 32'(exp_tab[i]));
      check($sformatf("tt_level_%0d", i), 32'(level), 32'd1);
    end
    u_if.valid_in = 1'b0;
    step();
    check("tt_empty", 32'(level), 32'd0);
    check("tt_txn", 32'(txn_count), 32'd9);

    // fill to DEPTH with downstream stalled, fifth operand must be held off
    u_if.ready_out = 1'b0;
    for (int k = 0; k < 4; k++) begin
      u_if.valid_in = 1'b1; u_if.data_bus_in = vals[k];
      check($sformatf("fill_ready_%0d", k), 32'(u_if.ready_in), 32'd1);
      step();
    end
    check("full_level", 32'(level), 32'd4);
    check("full_ready_in", 32'(u_if.ready_in), 32'd0);
    check("full_head", 32'(u_if.data_bus_out), 32'(exp_tab[vals[0]]));
    u_if.data_bus_in = vals[4];
    step();
    step();
    check("full_hold_level", 32'(level), 32'd4);
    check("full_hold_txn", 32'(txn_count), 32'd13);
    check("full_stable_head", 32'(u_if.data_bus_out), 32'(exp_tab[vals[0]]));
    u_if.ready_out = 1'b1;
    for (int j = 1; j < 5; j++) begin
      step();
      if (j == 2) u_if.valid_in = 1'b0;
      check($sformatf("drain_data_%0d", j), 32'(u_if.data_bus_out), 32'(exp_tab[vals[j]]));
    end
    check("drain_txn", 32'(txn_count), 32'd14);
    step();
    check("drain_empty", 32'(level), 32'd0);

    // simultaneous push and pop at level 2
    u_if.ready_out = 1'b0;
    u_if.valid_in = 1'b1; u_if.data_bus_in = 3'd7;
    step();
    u_if.data_bus_in = 3'd1;
    step();
    check("pp_level_before", 32'(level), 32'd2);
    u_if.data_bus_in = 3'd2; u_if.ready_out = 1'b1;
    step();
    u_if.valid_in = 1'b0;
    check("pp_level_same", 32'(level), 32'd2);
    check("pp_head1", 32'(u_if.data_bus_out), 32'(exp_tab[1]));
    step();
    check("pp_head2", 32'(u_if.data_bus_out), 32'(exp_tab[2]));
    check("pp_level1", 32'(level), 32'd1);
    step();
    check("pp_txn", 32'(txn_count), 32'd17);

    // asynchronous reset between edges with three results buffered
    u_if.ready_out = 1'b0;
    u_if.valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      u_if.data_bus_in = 3'(k * 2 + 1);
      step();
    end
    u_if.valid_in = 1'b0;
    check("ar_level_before", 32'(level), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid_out", 32'(u_if.valid_out), 32'd0);
    check("ar_level", 32'(level), 32'd0);
    check("ar_txn", 32'(txn_count), 32'd0);
    check("ar_data_out", 32'(u_if.data_bus_out), 32'd0);
    check("ar_ready_in", 32'(u_if.ready_in), 32'd1);
    #1;
    rst = 1'b0;
    step();
    u_if.valid_in = 1'b1; u_if.data_bus_in = 3'b110;
    step();
    u_if.valid_in = 1'b0;
    check("ar_first_out", 32'(u_if.data_bus_out), 32'h16);
    check("ar_first_level", 32'(level), 32'd1);
    check("ar_first_txn", 32'(txn_count), 32'd1);

    // counter wrap on the CNT_W=2 instance
    u_if2.ready_out = 1'b1;
    u_if2.valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      u_if2.data_bus_in = 3'(k + 3);
      step();
    end
    check("wrap_txn_max", 32'(txn_count2), 32'd3);
    check("wrap_data", 32'(u_if2.data_bus_out), 32'(exp_tab[5]));
    u_if2.data_bus_in = 3'd7;
    step();
    u_if2.valid_in = 1'b0;
    check("wrap_txn_zero", 32'(txn_count2), 32'd0);
    check("wrap_last_data", 32'(u_if2.data_bus_out), 32'(exp_tab[7]));
    check("wrap_level", 32'(level2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
